eg_cmd_seq: RTL

EG_CMD_SEQ -- requirements
Module: eg_cmd_seq

---
 rtl/eg_cmd_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/eg_cmd_seq.sv
// eg_cmd_seq: byte-command sequencer sitting between a UART receiver, a
// buffer memory, a compressor and a result sender.
//   0x00 -> load: two length bytes (LSB first), then that many data bytes
//   0x01 -> start compressor (only if a complete load exists)
//   0x02 -> start sender     (only if a complete load exists)
// DEPTH must equal 2**AW. Bytes beyond DEPTH are swallowed and flag overflow.
module eg_cmd_seq #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic [15:0]   data_len,
    output logic          loaded,
    output logic          enc_start,
    input  logic          enc_done,
    output logic          tx_start,
    input  logic          tx_done,
    output logic          busy,
    output logic          overflow,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        LOAD   = 3'd3,
        ENC    = 3'd4,
        SEND   = 3'd5
    } state_t;

    localparam logic [7:0]  CMD_LOAD = 8'h00;
    localparam logic [7:0]  CMD_ENC  = 8'h01;
    localparam logic [7:0]  CMD_SEND = 8'h02;
    // Capacity widened to 17 bits so DEPTH=256 (or larger AW) compares cleanly
    // against the 16-bit byte counter.
    localparam logic [16:0] DEPTH_W  = 17'(DEPTH);

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [15:0]   data_len_q, data_len_d;
    logic          loaded_q, loaded_d;
    logic          overflow_q, overflow_d;
    logic          enc_start_q, enc_start_d;
    logic          tx_start_q, tx_start_d;
    logic          err_q, err_d;

    logic [15:0]   cnt_inc;
    logic [15:0]   len_full;
    logic          in_range;

    assign cnt_inc  = cnt_q + 16'd1;           // never wraps: cnt_q < len_q <= 65535
    assign len_full = {rx_data, len_q[7:0]};   // length as completed by the high byte
    assign in_range = ({1'b0, cnt_q} < DEPTH_W);

    // State and output registers; everything returns to idle values on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            data_len_q  <= '0;
            loaded_q    <= 1'b0;
            overflow_q  <= 1'b0;
            enc_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_len_q  <= data_len_d;
            loaded_q    <= loaded_d;
            overflow_q  <= overflow_d;
            enc_start_q <= enc_start_d;
            tx_start_q  <= tx_start_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output decode; pulse outputs default low each cycle.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_len_d  = data_len_q;
        loaded_d    = loaded_q;
        overflow_d  = overflow_q;
        enc_start_d = 1'b0;
        tx_start_d  = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    unique case (rx_data)
                        CMD_LOAD: begin
                            state_d    = LEN_LO;
                            loaded_d   = 1'b0;
                            overflow_d = 1'b0;
                        end
                        CMD_ENC: begin
                            if (loaded_q) begin
                                state_d     = ENC;
                                enc_start_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CMD_SEND: begin
                            if (loaded_q) begin
                                state_d    = SEND;
                                tx_start_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end

            LEN_LO: begin
                if (rx_valid) begin
                    len_d   = {len_q[15:8], rx_data};
                    state_d = LEN_HI;
                end
            end

            LEN_HI: begin
                if (rx_valid) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        // Empty load completes immediately.
                        state_d    = IDLE;
                        loaded_d   = 1'b1;
                        data_len_d = 16'd0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = 16'd0;
                    end
                end
            end

            LOAD: begin
                if (rx_valid) begin
                    if (in_range) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cnt_q[AW-1:0];
                        mem_wdata_d = rx_data;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    cnt_d = cnt_inc;
                    // Leave on the same edge that raises the final write.
                    if (cnt_inc == len_q) begin
                        state_d    = IDLE;
                        loaded_d   = 1'b1;
                        data_len_d = len_q;
                    end
                end
            end

            ENC: begin
                if (rx_valid) err_d = 1'b1;
                // A done in the start-pulse cycle belongs to nothing we launched.
                if (enc_done && !enc_start_q) state_d = IDLE;
            end

            SEND: begin
                if (rx_valid) err_d = 1'b1;
                if (tx_done && !tx_start_q) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign data_len  = data_len_q;
    assign loaded    = loaded_q;
    assign overflow  = overflow_q;
    assign enc_start = enc_start_q;
    assign tx_start  = tx_start_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule
